// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: one action per edge (FLUSH > BUBBLE > LOAD > HOLD), saturating bubble/hold counters.
// Latency 1 cycle on LOAD; backpressure: upstream stall holds contents if downstream stalls, else inserts a NOP bubble.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                STAGE   = 2,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [5:0]        i_stall,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_bubble_cnt,
  output logic [CNT_W-1:0]  o_hold_cnt
);

  if (STAGE < 0 || STAGE > 4) begin : g_stage_chk
    $error("pipe_stage_reg: STAGE must be in 0..4");
  end

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  logic stall_up;
  logic stall_dn;
  logic unused_stall;

  assign stall_up     = i_stall[STAGE];
  assign stall_dn     = i_stall[STAGE+1];
  // Only this stage's two stall bits matter; the rest are sunk here.
  assign unused_stall = ^i_stall;

  act_e              act;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  act_e              state_q;
  logic [CNT_W-1:0]  bub_q, bub_d;
  logic [CNT_W-1:0]  hold_q, hold_d;

  always_comb begin
    act = ACT_HOLD;
    if (i_flush) begin
      act = ACT_FLUSH;
    end else if (!stall_up) begin
      act = ACT_LOAD;
    end else if (!stall_dn) begin
      act = ACT_BUBBLE;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (act)
      ACT_LOAD: begin
        valid_d = i_valid;
        data_d  = i_data;
      end
      ACT_BUBBLE, ACT_FLUSH: begin
        valid_d = 1'b0;
        data_d  = NOP_VAL;
      end
      default: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
    endcase
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    bub_d  = bub_q;
    hold_d = hold_q;
    if (i_cnt_clr) begin
      bub_d  = '0;
      hold_d = '0;
    end else begin
      if (act == ACT_BUBBLE && bub_q != {CNT_W{1'b1}}) begin
        bub_d = bub_q + CNT_W'(1);
      end
      if (act == ACT_HOLD && hold_q != {CNT_W{1'b1}}) begin
        hold_d = hold_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VAL;
      state_q <= ACT_FLUSH;
      bub_q   <= '0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      state_q <= act;
      bub_q   <= bub_d;
      hold_q  <= hold_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_state      = state_q;
  assign o_bubble_cnt = bub_q;
  assign o_hold_cnt   = hold_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (default params; STAGE=4/CNT_W=2/non-zero NOP) against a behavioural model.
module tb_pipe_stage_reg;

  localparam logic [63:0] NOP_B = 64'hDEAD_BEEF_0BAD_F00D;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [5:0]  i_stall = '0;
  logic        i_flush = 1'b0;
  logic        i_cnt_clr = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_data = '0;

  logic        a_valid, b_valid;
  logic [63:0] a_data, b_data;
  logic [1:0]  a_state, b_state;
  logic [15:0] a_bub, a_hold;
  logic [1:0]  b_bub, b_hold;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 i_clk = ~i_clk;

  pipe_stage_reg dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_cnt_clr(i_cnt_clr), .i_valid(i_valid), .i_data(i_data),
    .o_valid(a_valid), .o_data(a_data), .o_state(a_state),
    .o_bubble_cnt(a_bub), .o_hold_cnt(a_hold)
  );

  pipe_stage_reg #(.DATA_W(64), .NOP_VAL(NOP_B), .STAGE(4), .CNT_W(2)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_cnt_clr(i_cnt_clr), .i_valid(i_valid), .i_data(i_data),
    .o_valid(b_valid), .o_data(b_data), .o_state(b_state),
    .o_bubble_cnt(b_bub), .o_hold_cnt(b_hold)
  );

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [1:0]  st;
    int unsigned bub;
    int unsigned hold;
  } mstate_t;

  mstate_t m_a, m_b;

  function automatic mstate_t reset_of(input logic [63:0] nop);
    mstate_t r;
    r.v = 1'b0; r.d = nop; r.st = 2'd3; r.bub = 0; r.hold = 0;
    return r;
  endfunction

  // Action rules straight from the stall/flush truth table.
  function automatic mstate_t next_of(input mstate_t s, input int stage,
                                      input int unsigned cmax, input logic [63:0] nop);
    mstate_t r;
    r = s;
    if (i_flush) begin
      r.v = 1'b0; r.d = nop; r.st = 2'd3;
    end else if (i_stall[stage] && !i_stall[stage+1]) begin
      r.v = 1'b0; r.d = nop; r.st = 2'd2;
      if (r.bub < cmax) r.bub = r.bub + 1;
    end else if (!i_stall[stage]) begin
      r.v = i_valid; r.d = i_data; r.st = 2'd0;
    end else begin
      r.st = 2'd1;
      if (r.hold < cmax) r.hold = r.hold + 1;
    end
    if (i_cnt_clr) begin
      r.bub = 0; r.hold = 0;
    end
    return r;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_a <= reset_of(64'h0);
      m_b <= reset_of(NOP_B);
    end else begin
      m_a <= next_of(m_a, 2, 65535, 64'h0);
      m_b <= next_of(m_b, 4, 3, NOP_B);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("a.valid", 64'(a_valid), 64'(m_a.v));
      chk("a.data",  a_data,       m_a.d);
      chk("a.state", 64'(a_state), 64'(m_a.st));
      chk("a.bub",   64'(a_bub),   64'(m_a.bub));
      chk("a.hold",  64'(a_hold),  64'(m_a.hold));
      chk("b.valid", 64'(b_valid), 64'(m_b.v));
      chk("b.data",  b_data,       m_b.d);
      chk("b.state", 64'(b_state), 64'(m_b.st));
      chk("b.bub",   64'(b_bub),   64'(m_b.bub));
      chk("b.hold",  64'(b_hold),  64'(m_b.hold));
    end
  end

  task automatic cyc(input logic [5:0] s, input logic f, input logic c,
                     input logic v, input logic [63:0] d);
    i_stall = s; i_flush = f; i_cnt_clr = c; i_valid = v; i_data = d;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst a.valid", 64'(a_valid), 64'd0);
    chk("rst a.data",  a_data, 64'h0);
    chk("rst a.state", 64'(a_state), 64'd3);
    chk("rst a.cnts",  64'({a_bub, a_hold}), 64'd0);
    chk("rst b.data",  b_data, NOP_B);
    #10 i_rst_n = 1'b1;
    chk_en = 1'b1;

    cyc(6'b000000, 1'b0, 1'b0, 1'b1, 64'h1234);
    chk("load data",  a_data, 64'h1234);
    chk("load valid", 64'(a_valid), 64'd1);
    chk("load state", 64'(a_state), 64'd0);

    cyc(6'b010100, 1'b0, 1'b0, 1'b1, 64'h9999);
    chk("bubble data",  a_data, 64'h0);
    chk("bubble valid", 64'(a_valid), 64'd0);
    chk("bubble state", 64'(a_state), 64'd2);
    chk("bubble cnt",   64'(a_bub), 64'd1);
    chk("b bubble data", b_data, NOP_B);

    cyc(6'b000000, 1'b0, 1'b0, 1'b1, 64'hAA);
    repeat (3) cyc(6'b111100, 1'b0, 1'b0, 1'b1, 64'hBB);
    chk("hold data",  a_data, 64'hAA);
    chk("hold cnt",   64'(a_hold), 64'd3);
    chk("hold state", 64'(a_state), 64'd1);
    chk("b hold cnt", 64'(b_hold), 64'd3);

    cyc(6'b001100, 1'b1, 1'b0, 1'b1, 64'hCC);
    chk("flush data",  a_data, 64'h0);
    chk("flush valid", 64'(a_valid), 64'd0);
    chk("flush state", 64'(a_state), 64'd3);
    chk("flush cnts",  64'({a_bub, a_hold}), {32'd0, 16'd1, 16'd3});

    cyc(6'b000000, 1'b0, 1'b0, 1'b0, 64'h55);
    chk("load inv data",  a_data, 64'h55);
    chk("load inv valid", 64'(a_valid), 64'd0);

    repeat (5) cyc(6'b010100, 1'b0, 1'b0, 1'b1, 64'h1);
    chk("sat b bub", 64'(b_bub), 64'd3);
    chk("a bub 6",   64'(a_bub), 64'd6);
    cyc(6'b010100, 1'b0, 1'b1, 1'b1, 64'h1);
    chk("clr b bub", 64'(b_bub), 64'd0);
    chk("clr a bub", 64'(a_bub), 64'd0);
    chk("clr a hold", 64'(a_hold), 64'd0);

    cyc(6'b110011, 1'b0, 1'b0, 1'b1, 64'h3C3C);
    chk("other bits data",  a_data, 64'h3C3C);
    chk("other bits state", 64'(a_state), 64'd0);
    chk("b other bits state", 64'(b_state), 64'd1);

    cyc(6'b000000, 1'b0, 1'b0, 1'b1, 64'hAA);
    cyc(6'b111100, 1'b0, 1'b0, 1'b1, 64'hBB);
    #1 i_rst_n = 1'b0;
    #1;
    chk("async rst data",  a_data, 64'h0);
    chk("async rst valid", 64'(a_valid), 64'd0);
    chk("async rst state", 64'(a_state), 64'd3);
    chk("async rst hold",  64'(a_hold), 64'd0);
    chk("async rst b data", b_data, NOP_B);
    #1 i_rst_n = 1'b1;
    cyc(6'b111100, 1'b0, 1'b0, 1'b1, 64'h77);
    chk("post rst hold data",  a_data, 64'h0);
    chk("post rst hold state", 64'(a_state), 64'd1);
    chk("post rst hold cnt",   64'(a_hold), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0]  s;
      logic        f, c, v;
      logic [63:0] d;
      s = 6'($urandom);
      if ($urandom_range(3) == 0) s[2] = 1'b0;
      f = ($urandom_range(15) == 0);
      c = ($urandom_range(31) == 0);
      v = 1'($urandom);
      d = {$urandom, $urandom};
      cyc(s, f, c, v, d);
      if ($urandom_range(199) == 0) begin
        #1 i_rst_n = 1'b0;
        #1 i_rst_n = 1'b1;
      end
    end

    @(negedge i_clk);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
